ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, bitstream word width in bits.
REQ-002 SHALL have parameter CHAIN_LEN, default 1024, number of CCFF stages in the driven chain.
REQ-003 SHALL have port CK  input  1  single clock, rising edge; same clock as the CCFF chain.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a chain load.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a load in progress.
REQ-007 SHALL have port word_data  input  WORD_W  bitstream word; MSB is shifted first.
REQ-008 SHALL have port word_valid  input  1  word_data is valid.
REQ-009 SHALL have port word_ready  output  1  loader accepts the word this cycle.
REQ-010 SHALL have port chain_d  output  1  serial data to D of the first CCFF.
REQ-011 SHALL have port chain_shift  output  1  shift enable for the chain clock gate; the chain captures chain_d at CK when this is 1.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  chain fully loaded, level.
REQ-014 SHALL have port bit_cnt  output  $clog2(CHAIN_LEN+1)  bits shifted in the current load.

Function
REQ-015 SHALL implement states IDLE, FETCH, SHIFT and DONE.
REQ-016 SHALL move from IDLE or DONE to FETCH on start, clear bit_cnt, clear done, and set busy.
REQ-017 SHALL ignore start while busy.
REQ-018 SHALL drive word_ready=1 in FETCH.
REQ-019 SHALL also drive word_ready=1 in SHIFT on the last bit of the current word when bits remain after it, so back-to-back words shift with no gap.
REQ-020 SHALL accept a word on word_valid&&word_ready into a WORD_W shift register and enter or stay in SHIFT.
REQ-021 SHALL, in SHIFT, drive chain_d=shift register MSB and chain_shift=1, shift left by one and increment bit_cnt every cycle.
REQ-022 SHALL shift min(WORD_W, CHAIN_LEN-bit_cnt) bits per word and discard the unused low bits of the final word.
REQ-023 SHALL go to DONE when bit_cnt reaches CHAIN_LEN, setting done=1 and busy=0 the cycle after the last shift.
REQ-024 SHALL hold done until the next start or RST.
REQ-025 SHALL return to FETCH with chain_shift=0 and bit_cnt held when a word ends and no word is accepted (stall).
REQ-026 SHALL, on abort while busy, enter IDLE next cycle with chain_shift=0, busy=0, done=0 and bit_cnt=0; abort in IDLE or DONE has no effect.
REQ-027 SHALL let abort win over word acceptance in the same cycle; the word is not consumed (word_ready=0).
REQ-028 SHALL drive chain_d=0 whenever chain_shift=0.

Reset
REQ-029 SHALL on RST enter IDLE with word_ready, chain_d, chain_shift, busy, done and bit_cnt at 0 and the shift register cleared.
REQ-030 SHALL give RST priority over start and abort; RST mid-shift stops chain_shift the next cycle.

Configuration
REQ-031 SHALL, with CCFF_LOADER_CRC_EN defined, add output crc_out [15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout) over every bit with chain_shift=1, reinitialised on start, abort and RST, and held in DONE.
REQ-032 SHALL, without CCFF_LOADER_CRC_EN, omit the crc_out port and all CRC logic.

Structure
REQ-033 SHALL put the state enum, the CRC polynomial and init constants in shared package ccff_loader_pkg.
REQ-034 SHALL place the CRC datapath in sub-module ccff_loader_crc16, instantiated only under CCFF_LOADER_CRC_EN.

Verification (WORD_W=8)
REQ-035 SHALL cover: CHAIN_LEN=20, words 0xA5,0x3C,0xF0 with word_valid high -> chain_d=1010_0101_0011_1100_1111, 20 contiguous chain_shift cycles, done=1 the following cycle, bit_cnt=20.
REQ-036 SHALL cover: CHAIN_LEN=20, word_valid low for 3 cycles after the first word -> chain_shift low exactly 3 cycles, bit_cnt holds 8, final chain_d sequence unchanged.
REQ-037 SHALL cover: abort asserted when bit_cnt=5 -> chain_shift=0 next cycle, busy=0, done=0, bit_cnt=0, pending word not consumed.
REQ-038 SHALL cover: RST when bit_cnt=12 -> all outputs 0 next cycle; a subsequent start reloads all 20 bits correctly.
REQ-039 SHALL cover: start pulsed in SHIFT -> ignored, load completes normally; start in DONE -> done=0 and a new load begins.
REQ-040 SHALL cover, with CCFF_LOADER_CRC_EN: CHAIN_LEN=72, bytes 0x31..0x39 -> crc_out=0x29B1 at done.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the CCFF chain loader: FSM state encoding and CRC-16-CCITT constants.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first CRC step for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_loader_crc16.sv
// Serial CRC-16-CCITT over the bits shifted into the chain.
// Present only when the top is built with CCFF_LOADER_CRC_EN.
module ccff_loader_crc16
  import ccff_loader_pkg::*;
(
  input  logic        CK,
  input  logic        RST,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        din_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, din_i);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams WORD_W-bit bitstream words MSB-first into a CHAIN_LEN-stage CCFF chain.
// Define CCFF_LOADER_CRC_EN to add the crc_out port (CRC-16-CCITT of shifted bits).
//
// state | meaning
// IDLE  | no load active, bit_cnt cleared
// FETCH | waiting for the next word (word_ready=1), chain paused
// SHIFT | one bit into the chain per cycle
// DONE  | CHAIN_LEN bits loaded, done held until start/RST
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic                           CK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           abort,
  input  logic [WORD_W-1:0]              word_data,
  input  logic                           word_valid,
  output logic                           word_ready,
  output logic                           chain_d,
  output logic                           chain_shift,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic [15:0]                    crc_out
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  WORD_LAST  = WC_W'(WORD_W - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic               shifting, chain_end, word_end;
  logic               start_ok, abort_ok, accept;

  always_comb begin
    shifting    = (state_q == ST_SHIFT);
    chain_end   = shifting && (cnt_q == CHAIN_LAST);
    word_end    = shifting && (wcnt_q == WORD_LAST);
    busy        = (state_q == ST_FETCH) || shifting;
    done        = (state_q == ST_DONE);
    start_ok    = start && !busy;
    abort_ok    = abort && busy;
    // Ready on the last bit of a word lets the next word follow without a bubble.
    word_ready  = !RST && !abort &&
                  ((state_q == ST_FETCH) || (word_end && !chain_end));
    accept      = word_valid && word_ready;
    chain_shift = shifting;
    chain_d     = shifting && sreg_q[WORD_W-1];
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    if (shifting) begin
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q + CNT_W'(1);
      wcnt_d = wcnt_q + WC_W'(1);
      if (chain_end) begin
        state_d = ST_DONE;
      end else if (word_end) begin
        state_d = ST_FETCH;
      end
    end
    if (accept) begin
      sreg_d  = word_data;
      wcnt_d  = '0;
      state_d = ST_SHIFT;
    end
    if (start_ok) begin
      state_d = ST_FETCH;
      cnt_d   = '0;
    end
    if (abort_ok) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      wcnt_d  = '0;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bit_cnt = cnt_q;

`ifdef CCFF_LOADER_CRC_EN
  ccff_loader_crc16 u_crc (
    .CK     (CK),
    .RST    (RST),
    .init_i (start_ok || abort_ok),
    .en_i   (chain_shift),
    .din_i  (chain_d),
    .crc_o  (crc_out)
  );
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboarded bench for ccff_chain_loader (WORD_W=8, CHAIN_LEN=20).
module tb_ccff_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  logic             CK = 1'b0;
  logic             RST, start, abort, word_valid;
  logic [WORD_W-1:0] word_data;
  logic             word_ready, chain_d, chain_shift, busy, done;
  logic [CNT_W-1:0] bit_cnt;
`ifdef CCFF_LOADER_CRC_EN
  logic [15:0]      crc_out;
`endif

  ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .CK          (CK),
    .RST         (RST),
    .start       (start),
    .abort       (abort),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .chain_d     (chain_d),
    .chain_shift (chain_shift),
    .busy        (busy),
    .done        (done),
    .bit_cnt     (bit_cnt)
`ifdef CCFF_LOADER_CRC_EN
    ,
    .crc_out     (crc_out)
`endif
  );

  always #5 CK = ~CK;

  int   vectors = 0;
  int   miscompares = 0;
  bit   exp_q[$];      // chain bits still expected from the DUT
  bit   load_bits[$];  // every bit the current load should deliver
  int   pushed;
  int   shifts;
  int   gaps;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: a word contributes its bits MSB-first until the chain is full.
  task automatic push_word(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (pushed < CHAIN_LEN) begin
        exp_q.push_back(w[i]);
        load_bits.push_back(w[i]);
        pushed++;
      end
    end
  endtask

  function automatic logic [15:0] crc_ref();
    logic [15:0] c = 16'hFFFF;
    foreach (load_bits[i]) begin
      if (c[15] ^ load_bits[i]) c = (c << 1) ^ 16'h1021;
      else c = c << 1;
    end
    return c;
  endfunction

  // Monitor: every shifting cycle must carry the next expected chain bit.
  always @(negedge CK) begin
    if (chain_shift) begin
      if (exp_q.size() == 0) begin
        check("unexpected_shift", 32'(chain_shift), 32'd0);
      end else begin
        check("chain_d", 32'(chain_d), 32'(exp_q.pop_front()));
      end
      shifts++;
    end else begin
      check("chain_d_idle", 32'(chain_d), 32'd0);
      if (busy && shifts > 0) gaps++;
    end
  end

  task automatic expect_all_zero(input string tag);
    check({tag, "_ready"}, 32'(word_ready), 0);
    check({tag, "_chain_d"}, 32'(chain_d), 0);
    check({tag, "_shift"}, 32'(chain_shift), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
  endtask

  // One load: start pulse, three offered words, optional stall after word 0,
  // optional abort / RST / extra start fired when bit_cnt reaches a value.
  task automatic run_load(input logic [7:0] w0, w1, w2, input int stall_len,
                          input int abort_at, input int rst_at, input int start_at);
    logic [7:0] wv [3];
    int idx = 0, ready_seen = 0, last_shift = -10;
    bit fired = 0, finished = 0;
    wv[0] = w0; wv[1] = w1; wv[2] = w2;
    exp_q.delete(); load_bits.delete();
    pushed = 0; shifts = 0; gaps = 0;
    start = 1'b1; word_valid = 1'b0;
    @(posedge CK); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
    check("start_bit_cnt", 32'(bit_cnt), 0);
    check("start_ready", 32'(word_ready), 1);
    for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
      bit act_abort, act_rst, act_start;
      act_abort = !fired && abort_at >= 0 && int'(bit_cnt) == abort_at && busy;
      act_rst   = !fired && rst_at >= 0 && int'(bit_cnt) == rst_at && busy;
      act_start = !fired && start_at >= 0 && int'(bit_cnt) == start_at && busy;
      if (act_abort || act_rst || act_start) fired = 1;
      abort = act_abort; RST = act_rst; start = act_start;
      word_valid = (idx < 3) && !(idx == 1 && ready_seen < stall_len);
      word_data  = word_valid ? wv[idx] : 8'($urandom);
      @(negedge CK);
      if (busy && !chain_shift) check("fetch_bit_cnt", 32'(bit_cnt), 32'(pushed));
      if (act_abort) check("abort_ready", 32'(word_ready), 0);
      if (idx == 1 && word_ready && !word_valid) ready_seen++;
      if (word_valid && word_ready) begin
        push_word(wv[idx]);
        idx++;
      end
      if (chain_shift) last_shift = cyc;
      if (done) begin
        finished = 1;
        check("done_latency", 32'(cyc), 32'(last_shift + 1));
        check("done_bit_cnt", 32'(bit_cnt), CHAIN_LEN);
        check("done_busy", 32'(busy), 0);
        check("done_shifts", 32'(shifts), CHAIN_LEN);
        check("done_leftover", 32'(exp_q.size()), 0);
        check("stall_gaps", 32'(gaps), 32'(stall_len));
`ifdef CCFF_LOADER_CRC_EN
        check("crc_out", 32'(crc_out), 32'(crc_ref()));
`endif
      end
      @(posedge CK); #1;
      abort = 1'b0; start = 1'b0;
      if (act_abort) begin
        check("abort_shift", 32'(chain_shift), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_bit_cnt", 32'(bit_cnt), 0);
        check("abort_word_kept", 32'(idx), 32'(abort_at / WORD_W + (abort_at % WORD_W == 0 ? 0 : 1)));
        exp_q.delete();
        return;
      end
      if (act_rst) begin
        RST = 1'b0;
        expect_all_zero("rst_mid");
        exp_q.delete();
        return;
      end
    end
    if (!finished) check("load_timeout", 32'(done), 1);
    word_valid = 1'b0;
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
    repeat (3) @(posedge CK);
    #1;
    expect_all_zero("reset");
    RST = 1'b0;
    @(posedge CK); #1;

    run_load(8'hA5, 8'h3C, 8'hF0, 0, -1, -1, -1);
    run_load(8'hA5, 8'h3C, 8'hF0, 3, -1, -1, -1);
    run_load(8'hA5, 8'h3C, 8'hF0, 0, -1, -1, 10);
    run_load(8'hA5, 8'h3C, 8'hF0, 0, 5, -1, -1);
    run_load(8'h5A, 8'hC3, 8'h0F, 1, 8, -1, -1);
    run_load(8'hA5, 8'h3C, 8'hF0, 0, -1, 12, -1);
    run_load(8'hA5, 8'h3C, 8'hF0, 0, -1, -1, -1);

    for (int n = 0; n < 24; n++) begin
      int sel = $urandom_range(0, 3);
      run_load(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
               (sel == 1) ? $urandom_range(1, 18) : -1,
               (sel == 2) ? $urandom_range(1, 18) : -1,
               (sel == 3) ? $urandom_range(1, 18) : -1);
      repeat ($urandom_range(0, 2)) @(posedge CK);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
